// File: rtl/seven_segment_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver_pkg
// Shared constants and types for the multiplexed 7-segment scan driver.
//   SEG_BLANK / SEG_ZERO / SEG_MINUS : active-low patterns (bit0=a .. bit6=g)
//   DIGIT_COUNT                      : digits on the display
//   digits_t                         : four packed patterns, [0] = ones digit
//   slot_state_e                     : per-slot scan phase
// ---------------------------------------------------------------------------
package seven_segment_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_ZERO    = 7'h40;
  localparam logic [6:0] SEG_MINUS   = 7'h3F;
  localparam int         DIGIT_COUNT = 4;

  typedef logic [6:0] seg_t;
  typedef seg_t [DIGIT_COUNT-1:0] digits_t;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } slot_state_e;

  // Active-low one-cold anode enable for the given digit index.
  function automatic logic [3:0] anode_enable(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_zero_blanker.sv
// ---------------------------------------------------------------------------
// seven_segment_zero_blanker
// Leading-zero suppression on a set of four digit patterns (combinational).
//   en_i      : enable suppression
//   digits_i  : raw patterns, [3]=sign/blank, [2], [1], [0]=ones
//   digits_o  : patterns with leading zeros replaced by SEG_BLANK
// The sign position and the ones digit are never touched, so a value of
// zero still shows a single '0'.
// ---------------------------------------------------------------------------
module seven_segment_zero_blanker
  import seven_segment_scan_driver_pkg::*;
(
  input  logic    en_i,
  input  digits_t digits_i,
  output digits_t digits_o
);

  logic blank2;
  logic blank1;

  assign blank2 = en_i && (digits_i[2] == SEG_ZERO);
  // Digit 1 may only be suppressed when the zero to its left was.
  assign blank1 = blank2 && (digits_i[1] == SEG_ZERO);

  always_comb begin
    digits_o = digits_i;
    if (blank2) digits_o[2] = SEG_BLANK;
    if (blank1) digits_o[1] = SEG_BLANK;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver
// Scans a 4-digit common-anode display one digit per slot, with dead time
// at the start of every slot, PWM dimming and double-buffered patterns.
//   clock               : system clock, rising edge
//   resetn              : asynchronous active-low reset
//   seg1_in..seg4_in    : active-low patterns, seg1 = ones, seg4 = sign
//   update              : one-cycle strobe, captures seg*_in into the shadow
//   blank_leading_zeros : leading-zero suppression enable (sampled per frame)
//   brightness          : PWM level, 0 dimmest .. 15 full (sampled per frame)
//   seg_out             : active-low segment drive, registered
//   digit_an            : active-low anode enables, bit i = digit i
//   frame_done          : high for the last cycle of digit 3's slot
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_DEAD | slot counter < DEAD_CYCLES, all anodes off
// ST_ON   | remainder of the slot, digit driven while pwm <= brightness
// ---------------------------------------------------------------------------
module seven_segment_scan_driver
  import seven_segment_scan_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 500
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  input  logic [6:0] seg3_in,
  input  logic [6:0] seg4_in,
  input  logic       update,
  input  logic       blank_leading_zeros,
  input  logic [3:0] brightness,
  output logic [6:0] seg_out,
  output logic [3:0] digit_an,
  output logic       frame_done
);

  localparam int             CW       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_DEAD = CW'(DEAD_CYCLES);
  // With zero dead time the slot opens directly in ST_ON.
  localparam slot_state_e    ST_RST   = (DEAD_CYCLES > 0) ? ST_DEAD : ST_ON;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    pwm_q, pwm_d;
  slot_state_e   state_q, state_d;
  digits_t       shadow_q, shadow_d;
  digits_t       active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    bright_q, bright_d;
  logic          blank_q, blank_d;
  logic [6:0]    seg_out_q, seg_out_d;
  logic [3:0]    digit_an_q, digit_an_d;
  logic          frame_done_q, frame_done_d;

  digits_t seg_in;
  digits_t xfer_src;
  digits_t xfer_blanked;
  logic    slot_wrap;
  logic    boundary;
  logic    drive_on;

  assign seg_in    = {seg4_in, seg3_in, seg2_in, seg1_in};
  assign slot_wrap = (cnt_q == CNT_LAST);
  assign boundary  = slot_wrap && (idx_q == 2'd3);

  // An update landing exactly on the boundary bypasses the shadow so it is
  // not lost to the pending clear on the same edge.
  assign xfer_src  = update ? seg_in : shadow_q;

  seven_segment_zero_blanker u_blanker (
    .en_i     (blank_d),
    .digits_i (xfer_src),
    .digits_o (xfer_blanked)
  );

  always_comb begin
    cnt_d   = slot_wrap ? '0 : cnt_q + CW'(1);
    idx_d   = slot_wrap ? idx_q + 2'd1 : idx_q;
    state_d = (cnt_d < CNT_DEAD) ? ST_DEAD : ST_ON;
    // pwm reads 0 on the first ON cycle of every slot; its value during
    // dead time is irrelevant.
    pwm_d   = (cnt_d == CNT_DEAD) ? 4'd0 : pwm_q + 4'd1;

    bright_d = boundary ? brightness : bright_q;
    blank_d  = boundary ? blank_leading_zeros : blank_q;

    shadow_d  = update ? seg_in : shadow_q;
    pending_d = boundary ? 1'b0 : (pending_q | update);
    active_d  = (boundary && (update || pending_q)) ? xfer_blanked : active_q;

    frame_done_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);

    drive_on   = (state_q == ST_ON) && (pwm_q <= bright_q);
    seg_out_d  = drive_on ? active_q[idx_q] : SEG_BLANK;
    digit_an_d = drive_on ? anode_enable(idx_q) : 4'hF;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      pwm_q        <= 4'd0;
      state_q      <= ST_RST;
      shadow_q     <= {DIGIT_COUNT{SEG_BLANK}};
      active_q     <= {DIGIT_COUNT{SEG_BLANK}};
      pending_q    <= 1'b0;
      bright_q     <= 4'hF;
      blank_q      <= 1'b0;
      seg_out_q    <= SEG_BLANK;
      digit_an_q   <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      bright_q     <= bright_d;
      blank_q      <= blank_d;
      seg_out_q    <= seg_out_d;
      digit_an_q   <= digit_an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_an   = digit_an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;

  logic       clock = 1'b0;
  logic       resetn;
  logic [6:0] seg1_in, seg2_in, seg3_in, seg4_in;
  logic       update;
  logic       blank_leading_zeros;
  logic [3:0] brightness;

  logic [6:0] seg_out;
  logic [3:0] digit_an;
  logic       frame_done;
  logic [6:0] seg64;
  logic [3:0] an64;
  logic       fd64;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [6:0] cap_seg [32];
  logic [3:0] cap_an  [32];
  logic       cap_fd  [32];

  int n;

  always #5 clock = ~clock;

  seven_segment_scan_driver #(.DIGIT_CYCLES(8), .DEAD_CYCLES(2)) dut (
    .clock(clock), .resetn(resetn),
    .seg1_in(seg1_in), .seg2_in(seg2_in), .seg3_in(seg3_in), .seg4_in(seg4_in),
    .update(update), .blank_leading_zeros(blank_leading_zeros),
    .brightness(brightness),
    .seg_out(seg_out), .digit_an(digit_an), .frame_done(frame_done)
  );

  seven_segment_scan_driver #(.DIGIT_CYCLES(64), .DEAD_CYCLES(4)) dut64 (
    .clock(clock), .resetn(resetn),
    .seg1_in(seg1_in), .seg2_in(seg2_in), .seg3_in(seg3_in), .seg4_in(seg4_in),
    .update(update), .blank_leading_zeros(blank_leading_zeros),
    .brightness(brightness),
    .seg_out(seg64), .digit_an(an64), .frame_done(fd64)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 100);
    chk("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_fd64();
    int c;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (fd64 !== 1'b1 && c < 600);
    chk("frame_done64_seen", fd64, 1);
  endtask

  // Samples the 32 cycles following the current (boundary) cycle.
  task automatic capture_frame();
    for (int j = 0; j < 32; j++) begin
      @(negedge clock);
      cap_seg[j] = seg_out;
      cap_an[j]  = digit_an;
      cap_fd[j]  = frame_done;
      update     = 1'b0;
    end
  endtask

  task automatic count_slot(input logic [3:0] an_exp, output int cnt);
    cnt = 0;
    repeat (64) begin
      @(negedge clock);
      if (an64 === an_exp) cnt++;
    end
  endtask

  task automatic drive_update(input logic [6:0] s4, input logic [6:0] s3,
                              input logic [6:0] s2, input logic [6:0] s1);
    seg4_in = s4; seg3_in = s3; seg2_in = s2; seg1_in = s1;
    update  = 1'b1;
    @(negedge clock);
    update  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    seg1_in = 7'h7F; seg2_in = 7'h7F; seg3_in = 7'h7F; seg4_in = 7'h7F;
    update = 1'b0;
    blank_leading_zeros = 1'b1;
    brightness = 4'hF;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_an", digit_an, 4'hF);
    chk("rst_fd", frame_done, 0);
    resetn = 1'b1;

    // 1: blank buffers, anode scan, frame period
    wait_fd(n);
    chk("first_fd_cycles", n, 31);
    capture_frame();
    chk("t1_an_j0", cap_an[0], 4'h7);
    chk("t1_an_j1", cap_an[1], 4'hF);
    chk("t1_an_j2", cap_an[2], 4'hF);
    chk("t1_an_d0", cap_an[3], 4'hE);
    chk("t1_an_d0_tail", cap_an[8], 4'hE);
    chk("t1_an_d1", cap_an[11], 4'hD);
    chk("t1_an_d2", cap_an[19], 4'hB);
    chk("t1_an_d3", cap_an[27], 4'h7);
    chk("t1_seg_d0", cap_seg[3], 7'h7F);
    chk("t1_seg_d3", cap_seg[27], 7'h7F);
    chk("t1_fd_j23", cap_fd[23], 0);
    chk("t1_fd_j30", cap_fd[30], 0);
    chk("t1_fd_j31", cap_fd[31], 1);

    // 2: leading-zero blanking on, pattern -, 0, 0, 12
    repeat (3) @(negedge clock);
    blank_leading_zeros = 1'b1;
    drive_update(7'h3F, 7'h40, 7'h40, 7'h12);
    wait_fd(n);
    chk("t2_fd_cycles", n, 28);
    capture_frame();
    chk("t2_seg_j0_old", cap_seg[0], 7'h7F);
    chk("t2_seg_d0", cap_seg[3], 7'h12);
    chk("t2_an_d0", cap_an[3], 4'hE);
    chk("t2_seg_d0_tail", cap_seg[8], 7'h12);
    chk("t2_dead_seg_j9", cap_seg[9], 7'h7F);
    chk("t2_dead_an_j9", cap_an[9], 4'hF);
    chk("t2_dead_seg_j10", cap_seg[10], 7'h7F);
    chk("t2_dead_an_j10", cap_an[10], 4'hF);
    chk("t2_seg_d1", cap_seg[11], 7'h7F);
    chk("t2_an_d1", cap_an[11], 4'hD);
    chk("t2_seg_d2", cap_seg[19], 7'h7F);
    chk("t2_seg_d3", cap_seg[27], 7'h3F);
    chk("t2_dead_an_j26", cap_an[26], 4'hF);

    // 2b: same pattern, blanking off
    repeat (3) @(negedge clock);
    blank_leading_zeros = 1'b0;
    drive_update(7'h3F, 7'h40, 7'h40, 7'h12);
    wait_fd(n);
    capture_frame();
    chk("t2b_seg_j0_old", cap_seg[0], 7'h3F);
    chk("t2b_seg_d0", cap_seg[3], 7'h12);
    chk("t2b_seg_d1", cap_seg[11], 7'h40);
    chk("t2b_seg_d2", cap_seg[19], 7'h40);
    chk("t2b_seg_d3", cap_seg[27], 7'h3F);

    // 2c: digit 2 non-zero keeps a zero in digit 1
    repeat (3) @(negedge clock);
    blank_leading_zeros = 1'b1;
    drive_update(7'h7F, 7'h79, 7'h40, 7'h24);
    wait_fd(n);
    capture_frame();
    chk("t2c_seg_d0", cap_seg[3], 7'h24);
    chk("t2c_seg_d1", cap_seg[11], 7'h40);
    chk("t2c_seg_d2", cap_seg[19], 7'h79);
    chk("t2c_seg_d3", cap_seg[27], 7'h7F);
    chk("t2c_an_d3", cap_an[27], 4'h7);

    // 4: PWM duty on the 64/4 instance, brightness frame-stable
    brightness = 4'hF;
    wait_fd64();
    @(negedge clock);
    count_slot(4'hE, n);
    chk("t4_on_b15", n, 60);
    brightness = 4'h7;
    count_slot(4'hD, n);
    chk("t4_midframe_b7_ignored", n, 60);
    wait_fd64();
    @(negedge clock);
    count_slot(4'hE, n);
    chk("t4_on_b7", n, 32);
    brightness = 4'h0;
    count_slot(4'hD, n);
    chk("t4_midframe_b0_ignored", n, 32);
    wait_fd64();
    @(negedge clock);
    count_slot(4'hE, n);
    chk("t4_on_b0", n, 4);

    // 5: two mid-frame updates, last one wins at the boundary
    brightness = 4'hF;
    wait_fd(n);
    @(negedge clock);
    drive_update(7'h02, 7'h12, 7'h19, 7'h30);
    drive_update(7'h08, 7'h10, 7'h00, 7'h78);
    @(negedge clock);
    chk("t5_hold_seg_d0", seg_out, 7'h24);
    chk("t5_hold_an_d0", digit_an, 4'hE);
    wait_fd(n);
    capture_frame();
    chk("t5_seg_j0_old", cap_seg[0], 7'h7F);
    chk("t5_seg_d0", cap_seg[3], 7'h78);
    chk("t5_seg_d1", cap_seg[11], 7'h00);
    chk("t5_seg_d2", cap_seg[19], 7'h10);
    chk("t5_seg_d3", cap_seg[27], 7'h08);
    chk("t5_fd_j31", cap_fd[31], 1);

    // 5b: update coincident with frame_done takes that cycle's inputs
    chk("t5b_fd_now", frame_done, 1);
    seg4_in = 7'h3F; seg3_in = 7'h40; seg2_in = 7'h40; seg1_in = 7'h40;
    update = 1'b1;
    capture_frame();
    chk("t5b_seg_j0_old", cap_seg[0], 7'h08);
    chk("t5b_seg_d0", cap_seg[3], 7'h40);
    chk("t5b_seg_d1", cap_seg[11], 7'h7F);
    chk("t5b_an_d1", cap_an[11], 4'hD);
    chk("t5b_seg_d2", cap_seg[19], 7'h7F);
    chk("t5b_seg_d3", cap_seg[27], 7'h3F);

    // 6: asynchronous reset in an ON window
    repeat (4) @(negedge clock);
    chk("t6_pre_an", digit_an, 4'hE);
    chk("t6_pre_seg", seg_out, 7'h40);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_an", digit_an, 4'hF);
    chk("t6_async_seg", seg_out, 7'h7F);
    chk("t6_async_fd", frame_done, 0);
    @(negedge clock);
    resetn = 1'b1;
    wait_fd(n);
    chk("t6_fd_cycles", n, 31);
    capture_frame();
    chk("t6_seg_d0", cap_seg[3], 7'h7F);
    chk("t6_an_d0", cap_an[3], 4'hE);
    chk("t6_seg_d3", cap_seg[27], 7'h7F);
    chk("t6_an_d3", cap_an[27], 4'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
- Downstream of the binary-to-seven-segment stage. Consumes its four active-low 7-bit digit patterns: seg4 (sign/blank), seg3, seg2 and seg1 (ones).
- Drives a 4-digit multiplexed common-anode display. It scans one digit at a time, inserts dead time between digits, dims by PWM and blanks leading zeros.
- Digit patterns are double-buffered, so a display update never tears mid-frame.

Parameters:
- DIGIT_CYCLES, 50000, clocks per digit slot (1 ms at 50 MHz); must be >= 2.
- DEAD_CYCLES, 500, clocks at the start of each slot with all anodes off; must be < DIGIT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seg1_in, seg2_in, seg3_in, seg4_in  in  7 each  active-low patterns, bit0=a … bit6=g.
- update  in  1  one-cycle strobe; captures seg*_in into the shadow buffer.
- blank_leading_zeros  in  1  enables leading-zero suppression.
- brightness  in  4  PWM level; 0 = dimmest, 15 = full.
- seg_out  out  7  active-low segment drive, registered.
- digit_an  out  4  active-low anode enables, registered; bit i = digit i, where digit0 = seg1.
- frame_done  out  1  one-cycle pulse on the last cycle of digit 3's slot.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (resetn).
- Reset (asynchronous, immediate):
  - seg_out=7'h7F, digit_an=4'hF, frame_done=0.
  - Active and shadow buffers = 7'h7F; pending=0.
  - digit index=0, slot counter=0, pwm counter=0.
- Capture on update: shadow <= seg*_in; pending <= 1. With several updates in one frame, the last one wins.
- Frame boundary = the cycle where index=3 and slot counter=DIGIT_CYCLES-1. On that edge:
  - Active buffer <= blanked(seg*_in) if update is high that cycle; else blanked(shadow) if pending; else unchanged.
  - pending cleared.
  - brightness and blank_leading_zeros sampled into their frame-stable registers.
  - frame_done pulses high during the boundary cycle.
- Blanking (applied on transfer into the active buffer):
  - Zero pattern = 7'h40.
  - Digit 2 (seg3) becomes 7'h7F if it equals 7'h40.
  - Digit 1 (seg2) becomes 7'h7F if digit 2 was blanked and seg2 equals 7'h40.
  - Digits 0 and 3 always pass through unchanged.
- Scan:
  - Slot counter runs 0..DIGIT_CYCLES-1, then wraps.
  - The digit index increments on wrap: 0→1→2→3→0.
- State per slot:
  - DEAD while counter < DEAD_CYCLES.
  - ON otherwise.
  - The pwm counter is cleared entering ON, then increments mod 16.
- Drive:
  - In ON with pwm <= brightness_reg: digit_an = ~(1<<index), seg_out = active[index].
  - Otherwise: digit_an = 4'hF, seg_out = 7'h7F.
  - Outputs are registered, one cycle behind the counter state.
- Latency: an update becomes visible at most one frame plus DEAD_CYCLES+1 cycles later.
- Reset mid-frame: outputs go dark with no clock edge. Scanning restarts at digit 0 with blank buffers.

Decomposition:
- Shared package constants: SEG_BLANK=7'h7F, SEG_ZERO=7'h40, SEG_MINUS=7'h3F, DIGIT_COUNT=4.
- One combinational sub-module: seven_segment_zero_blanker, which maps 4 patterns plus an enable to 4 blanked patterns.

Test Plan:
All scenarios use DIGIT_CYCLES=8, DEAD_CYCLES=2 unless stated.
1. Reset, then no update → digit_an cycles 4'hE/D/B/7 during ON windows, but seg_out stays 7'h7F throughout; frame_done pulses every 32 cycles.
2. update with seg4=3F, seg3=40, seg2=40, seg1=12, blank=1, brightness=15 → next frame shows digit3=3F, digit2=7F, digit1=7F, digit0=12. Repeat with blank=0 → digit2 and digit1 show 40.
3. Dead time → in counter cycles 0..1 of every slot, digit_an=F and seg_out=7F. Cycles 2..7 drive the digit at brightness 15.
4. DIGIT_CYCLES=64, DEAD_CYCLES=4 → anode-low cycles per slot are 60 at brightness 15, 32 at brightness 7, and 4 at brightness 0. A brightness change mid-frame takes effect only in the next frame.
5. Mid-frame update A, then update B → display unchanged until frame_done, then shows B. An update coincident with frame_done shows that cycle's inputs in the next frame.
6. Assert resetn low mid-ON-window → digit_an=F and seg_out=7F immediately, with no clock edge. After release, the display stays blank until a new update arrives.
